// File: rtl/fma_quire_acc.sv
// Multi-channel fixed-point quire accumulator with a one-deep flush result register.
// Define FMA_QUIRE_SAT_EN to clamp overflowing accumulations instead of wrapping.
module fma_quire_acc #(
  parameter int FX_B  = 64,
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        cmd_i,
  input  logic [CH_W-1:0]   ch_i,
  input  logic [FX_B-1:0]   addend_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CH_W-1:0]   out_ch_o,
  output logic [FX_B-1:0]   out_fixed_o,
  output logic              out_ovf_o,
  output logic [CNT_W-1:0]  out_cnt_o,
  output logic [NCH-1:0]    busy_o
);

  typedef enum logic [1:0] {
    CMD_INIT  = 2'b00,
    CMD_ACC   = 2'b01,
    CMD_FLUSH = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  typedef enum logic {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } ch_state_e;

  localparam logic [FX_B-1:0]  FX_MAX  = {1'b0, {(FX_B-1){1'b1}}};
  localparam logic [FX_B-1:0]  FX_MIN  = {1'b1, {(FX_B-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ch_state_e        state_q [NCH];
  ch_state_e        state_d [NCH];
  logic [FX_B-1:0]  acc_q   [NCH];
  logic [FX_B-1:0]  acc_d   [NCH];
  logic             ovf_q   [NCH];
  logic             ovf_d   [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];

  logic             out_valid_q;
  logic [CH_W-1:0]  out_ch_q;
  logic [FX_B-1:0]  out_fixed_q;
  logic             out_ovf_q;
  logic [CNT_W-1:0] out_cnt_q;

  cmd_e             cmd;
  logic             accept;
  logic             ch_ok;
  logic [FX_B-1:0]  base_acc;
  logic             base_ovf;
  logic [CNT_W-1:0] base_cnt;
  logic [FX_B-1:0]  sum;
  logic             add_ovf;
  logic [FX_B-1:0]  acc_res;
  logic [CNT_W-1:0] cnt_inc;

  assign cmd        = cmd_e'(cmd_i);
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign ch_ok      = (32'(ch_i) < NCH);

  // An IDLE channel reads as all-zero, so ACC/FLUSH on it start from a clean slate.
  always_comb begin
    base_acc = '0;
    base_ovf = 1'b0;
    base_cnt = '0;
    for (int k = 0; k < NCH; k++) begin
      if (32'(ch_i) == k && state_q[k] == CH_ACTIVE) begin
        base_acc = acc_q[k];
        base_ovf = ovf_q[k];
        base_cnt = cnt_q[k];
      end
    end
  end

  assign sum     = base_acc + addend_i;
  assign add_ovf = (base_acc[FX_B-1] == addend_i[FX_B-1]) &&
                   (sum[FX_B-1] != base_acc[FX_B-1]);
  assign cnt_inc = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CNT_W'(1);

`ifdef FMA_QUIRE_SAT_EN
  assign acc_res = add_ovf ? (base_acc[FX_B-1] ? FX_MIN : FX_MAX) : sum;
`else
  assign acc_res = sum;
`endif

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      state_d[k] = state_q[k];
      acc_d[k]   = acc_q[k];
      ovf_d[k]   = ovf_q[k];
      cnt_d[k]   = cnt_q[k];
    end
    if (accept && ch_ok) begin
      for (int k = 0; k < NCH; k++) begin
        if (32'(ch_i) == k) begin
          case (cmd)
            CMD_INIT: begin
              state_d[k] = CH_ACTIVE;
              acc_d[k]   = addend_i;
              ovf_d[k]   = 1'b0;
              cnt_d[k]   = CNT_W'(1);
            end
            CMD_ACC: begin
              state_d[k] = CH_ACTIVE;
              acc_d[k]   = acc_res;
              ovf_d[k]   = base_ovf || add_ovf;
              cnt_d[k]   = cnt_inc;
            end
            default: begin
              state_d[k] = CH_IDLE;
              acc_d[k]   = '0;
              ovf_d[k]   = 1'b0;
              cnt_d[k]   = '0;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= CH_IDLE;
        acc_q[k]   <= '0;
        ovf_q[k]   <= 1'b0;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= state_d[k];
        acc_q[k]   <= acc_d[k];
        ovf_q[k]   <= ovf_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  // Result register: a new FLUSH may replace the result in the same cycle it is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_fixed_q <= '0;
      out_ovf_q   <= 1'b0;
      out_cnt_q   <= '0;
    end else if (accept && ch_ok && cmd == CMD_FLUSH) begin
      out_valid_q <= 1'b1;
      out_ch_q    <= ch_i;
      out_fixed_q <= base_acc;
      out_ovf_q   <= base_ovf;
      out_cnt_q   <= base_cnt;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int k = 0; k < NCH; k++) begin
      busy_o[k] = (state_q[k] == CH_ACTIVE);
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_ch_o    = out_ch_q;
  assign out_fixed_o = out_fixed_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_cnt_o   = out_cnt_q;

endmodule
